// File: rtl/lb_pkg.sv
// Shared definitions for the SDRAM line-buffer fetch block.
// Holds the line/frame geometry constants and the fetch FSM state type.
// Ports: none (package only).
package lb_pkg;

  localparam int LB_WORDS_PER_LINE = 80;   // 640 pixels / 8 pixels per word
  localparam int LB_LINES          = 480;
  localparam int LB_H_ACTIVE       = 640;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RELEASE
  } lb_state_t;

endpackage

// File: rtl/lb_ram.sv
// Two-bank line buffer: 160 words of 128 bits.
// Bank b, word w lives at entry b*80 + w.
// The write port stores whole words. The read port selects one 16-bit pixel
// and registers it, so a pixel appears one clock after its address.
// Ports:
//   clk               - clock
//   we, wbank, waddr  - write enable, bank and word index
//   wdata             - 128-bit word to store (pixel 0 in bits [15:0])
//   rbank, raddr      - read bank and word index
//   rsel              - pixel index within the word
//   rdata             - registered 16-bit pixel
module lb_ram
  import lb_pkg::*;
(
  input  logic         clk,
  input  logic         we,
  input  logic         wbank,
  input  logic [6:0]   waddr,
  input  logic [127:0] wdata,
  input  logic         rbank,
  input  logic [6:0]   raddr,
  input  logic [2:0]   rsel,
  output logic [15:0]  rdata
);

  logic [127:0] mem [0:2*LB_WORDS_PER_LINE-1];
  logic [7:0]   widx;
  logic [7:0]   ridx;
  logic [127:0] rword;

  assign widx = wbank ? (8'(waddr) + 8'(LB_WORDS_PER_LINE)) : 8'(waddr);

  // Word indices past the end of a line only occur in horizontal blanking,
  // where the pixel is masked anyway; keep the read in range.
  always_comb begin
    ridx = 8'd0;
    if (raddr < 7'(LB_WORDS_PER_LINE))
      ridx = rbank ? (8'(raddr) + 8'(LB_WORDS_PER_LINE)) : 8'(raddr);
  end

  assign rword = mem[ridx];

  always_ff @(posedge clk) begin
    if (we)
      mem[widx] <= wdata;
  end

  // ---- read stage p1 ----
  always_ff @(posedge clk) begin
    rdata <= rword[{rsel, 4'b0000} +: 16];
  end

endmodule

// File: rtl/lb_sdram_fetch.sv
// Line-buffer fetch engine: pulls one 640-pixel line (80 x 128-bit words)
// from SDRAM into a two-bank buffer while the previous line is displayed,
// and serves the pixel for the current DrawX/DrawY one clock later.
// Optional feature macro: LB_FB_SWAP_EN -- alternate between framebuffers
// FB_BASE0 and FB_BASE1 on each accepted new_frame.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   new_frame             - frame-start strobe (restarts at line 0 when idle)
//   DrawX, DrawY          - current VGA pixel coordinates
//   lb_sdram_Wait         - 0 = SDRAM port granted to this block
//   lb_sdram_ac           - read acknowledge, lb_sdram_data valid this cycle
//   lb_sdram_data         - 8 pixels of read data
//   lb_sdram_rd           - read request
//   lb_sdram_addr         - read word address
//   lb_Busy               - a line fetch is pending or in progress
//   lb_done               - the last line of the frame has been fetched
//   pixel                 - pixel for the registered DrawX/DrawY
module lb_sdram_fetch
  import lb_pkg::*;
#(
  parameter logic [21:0] FB_BASE0 = 22'h000000,
  parameter logic [21:0] FB_BASE1 = 22'h009600
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         new_frame,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         lb_sdram_Wait,
  input  logic         lb_sdram_ac,
  input  logic [127:0] lb_sdram_data,
  output logic         lb_sdram_rd,
  output logic [21:0]  lb_sdram_addr,
  output logic         lb_Busy,
  output logic         lb_done,
  output logic [15:0]  pixel
);

  lb_state_t   state;
  lb_state_t   state_next;
  logic [8:0]  line;
  logic [6:0]  word;
  logic        last;
  logic [21:0] base;
  logic [21:0] line_off;
  logic        accept;
  logic        word_end;
  logic        line_end;
  logic        frame_restart;
  logic        in_range_p1;
  logic [15:0] pixel_raw_p1;

`ifdef LB_FB_SWAP_EN
  logic fsel;
  assign base = fsel ? FB_BASE1 : FB_BASE0;
`else
  // FB_BASE1 only matters for framebuffer swapping; fold it away here.
  logic unused_base1;
  assign unused_base1 = ^FB_BASE1;
  assign base = FB_BASE0;
`endif

  // line*80 as two shifts keeps this a pair of adders.
  assign line_off      = ({13'd0, line} << 6) + ({13'd0, line} << 4);
  assign lb_sdram_addr = base + line_off + {15'd0, word};

  // An acknowledge outside FETCH belongs to nobody and is dropped.
  assign accept        = (state == ST_FETCH) && lb_sdram_ac;
  assign word_end      = (word == 7'(LB_WORDS_PER_LINE - 1));
  assign line_end      = (line == 9'(LB_LINES - 1));
  assign frame_restart = new_frame && (state != ST_FETCH);

  always_comb begin
    state_next  = state;
    lb_sdram_rd = 1'b0;
    lb_Busy     = 1'b1;
    lb_done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!lb_sdram_Wait)
          state_next = ST_FETCH;
      end
      ST_FETCH: begin
        // Losing the grant only drops the request; the word position is kept.
        lb_sdram_rd = !lb_sdram_Wait;
        if (accept && word_end)
          state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        lb_Busy = 1'b0;
        lb_done = last;
        if (lb_sdram_Wait)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      line  <= '0;
      word  <= '0;
      last  <= 1'b0;
`ifdef LB_FB_SWAP_EN
      fsel  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        if (word_end) begin
          word <= '0;
          if (line_end) begin
            line <= '0;
            last <= 1'b1;
          end else begin
            line <= line + 9'd1;
          end
        end else begin
          word <= word + 7'd1;
        end
      end else if (frame_restart) begin
        line <= '0;
        word <= '0;
`ifdef LB_FB_SWAP_EN
        fsel <= ~fsel;
`endif
      end
      if ((state == ST_RELEASE) && lb_sdram_Wait)
        last <= 1'b0;
    end
  end

  lb_ram u_ram (
    .clk   (clk),
    .we    (accept),
    .wbank (line[0]),
    .waddr (word),
    .wdata (lb_sdram_data),
    .rbank (DrawY[0]),
    .raddr (DrawX[9:3]),
    .rsel  (DrawX[2:0]),
    .rdata (pixel_raw_p1)
  );

  // ---- read stage p1: blanking mask aligned with the registered pixel ----
  always_ff @(posedge clk) begin
    if (!reset)
      in_range_p1 <= 1'b0;
    else
      in_range_p1 <= (DrawX < 10'(LB_H_ACTIVE)) && (DrawY < 10'(LB_LINES));
  end

  assign pixel = in_range_p1 ? pixel_raw_p1 : 16'h0000;

endmodule

// File: tb/tb_lb_sdram_fetch.sv
// Directed bench for lb_sdram_fetch (default build, LB_FB_SWAP_EN undefined).
module tb_lb_sdram_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         new_frame;
  logic [9:0]   DrawX;
  logic [9:0]   DrawY;
  logic         lb_sdram_Wait;
  logic         lb_sdram_ac;
  logic [127:0] lb_sdram_data;
  logic         lb_sdram_rd;
  logic [21:0]  lb_sdram_addr;
  logic         lb_Busy;
  logic         lb_done;
  logic [15:0]  pixel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lb_sdram_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .new_frame     (new_frame),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .lb_sdram_Wait (lb_sdram_Wait),
    .lb_sdram_ac   (lb_sdram_ac),
    .lb_sdram_data (lb_sdram_data),
    .lb_sdram_rd   (lb_sdram_rd),
    .lb_sdram_addr (lb_sdram_addr),
    .lb_Busy       (lb_Busy),
    .lb_done       (lb_done),
    .pixel         (pixel)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Word w of line l: pixel k = {1, l[0], 0000, w[6:0], k[2:0]};
  // line 0 word 5 is the plain ramp 0..7.
  function automatic logic [127:0] pat(input int l, input int w);
    logic [127:0] r;
    logic [15:0]  px;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (l == 0 && w == 5) px = 16'(k);
      else                  px = {1'b1, 1'(l % 2), 4'b0000, 7'(w), 3'(k)};
      r[k*16 +: 16] = px;
    end
    return r;
  endfunction

  // Waits (bounded) for a request, compares its address, then acknowledges it.
  task automatic do_word(input logic [21:0] ea, input logic [127:0] d,
                         input bit gap, output bit ok);
    int n;
    n = 0;
    while (lb_sdram_rd !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (lb_sdram_rd !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    ok = (lb_sdram_addr === ea);
    lb_sdram_ac   = 1'b1;
    lb_sdram_data = d;
    @(negedge clk);
    lb_sdram_ac = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic fetch_line(input int l, input bit gap, output int nbad);
    bit ok;
    nbad = 0;
    for (int w = 0; w < 80; w++) begin
      do_word(22'(l * 80 + w), pat(l, w), gap, ok);
      if (!ok) nbad++;
    end
  endtask

  task automatic release_exit();
    lb_sdram_Wait = 1'b1;
    @(negedge clk);
    lb_sdram_Wait = 1'b0;
  endtask

  task automatic show(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int nbad;
    int fast_bad;

    reset = 1'b0; new_frame = 1'b0; DrawX = '0; DrawY = '0;
    lb_sdram_Wait = 1'b1; lb_sdram_ac = 1'b0; lb_sdram_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rd",    32'(lb_sdram_rd),   32'd0);
    chk("rst_addr",  32'(lb_sdram_addr), 32'd0);
    chk("rst_done",  32'(lb_done),       32'd0);
    chk("rst_busy",  32'(lb_Busy),       32'd1);
    chk("rst_pixel", 32'(pixel),         32'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_grant_rd", 32'(lb_sdram_rd), 32'd0);
    lb_sdram_Wait = 1'b0;

    // Line 0 with ac every second cycle, a new_frame at word 30 and a grant
    // revocation after the 40th acknowledge.
    nbad = 0;
    for (int w = 0; w < 30; w++) begin
      do_word(22'(w), pat(0, w), 1'b1, ok);
      if (!ok) nbad++;
    end
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    chk("nf_fetch_addr", 32'(lb_sdram_addr), 32'd30);
    chk("nf_fetch_rd",   32'(lb_sdram_rd),   32'd1);
    for (int w = 30; w < 40; w++) begin
      do_word(22'(w), pat(0, w), 1'b1, ok);
      if (!ok) nbad++;
    end
    lb_sdram_Wait = 1'b1;
    @(negedge clk);
    chk("pause_rd",   32'(lb_sdram_rd), 32'd0);
    repeat (2) @(negedge clk);
    chk("pause_rd_hold", 32'(lb_sdram_rd), 32'd0);
    chk("pause_busy",    32'(lb_Busy),     32'd1);
    lb_sdram_Wait = 1'b0;
    #1;
    chk("regrant_rd",   32'(lb_sdram_rd),   32'd1);
    chk("regrant_addr", 32'(lb_sdram_addr), 32'd40);
    @(negedge clk);
    for (int w = 40; w < 80; w++) begin
      do_word(22'(w), pat(0, w), 1'b1, ok);
      if (!ok) nbad++;
    end
    chk("line0_addrs", 32'(nbad), 32'd0);
    chk("rel0_busy", 32'(lb_Busy),     32'd0);
    chk("rel0_rd",   32'(lb_sdram_rd), 32'd0);
    chk("rel0_done", 32'(lb_done),     32'd0);

    // Pixel readout from bank 0 (DUT stays in RELEASE while Wait=0)
    show(10'd42, 10'd0);
    chk("px_x42", 32'(pixel), 32'h0002);
    show(10'd45, 10'd0);
    chk("px_x45", 32'(pixel), 32'h0005);
    show(10'd8, 10'd0);
    chk("px_x8", 32'(pixel), 32'h8008);
    show(10'd639, 10'd0);
    chk("px_x639", 32'(pixel), 32'h827F);
    show(10'd700, 10'd0);
    chk("px_x700", 32'(pixel), 32'h0000);
    show(10'd42, 10'd480);
    chk("px_y480", 32'(pixel), 32'h0000);
    release_exit();

    // Lines 1..478 at full rate
    fast_bad = 0;
    for (int l = 1; l < 479; l++) begin
      fetch_line(l, 1'b0, nbad);
      fast_bad += nbad;
      if (lb_Busy !== 1'b0 || lb_done !== 1'b0) fast_bad++;
      release_exit();
    end
    chk("lines_1_478_addrs", 32'(fast_bad), 32'd0);

    // Last line of the frame
    fetch_line(479, 1'b0, nbad);
    chk("line479_addrs", 32'(nbad), 32'd0);
    chk("rel479_done", 32'(lb_done), 32'd1);
    chk("rel479_busy", 32'(lb_Busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("rel479_done_hold", 32'(lb_done), 32'd1);
    lb_sdram_Wait = 1'b1;
    @(negedge clk);
    chk("done_clear", 32'(lb_done), 32'd0);
    chk("idle_busy",  32'(lb_Busy), 32'd1);
    lb_sdram_Wait = 1'b0;

    // Line counter wrapped: next fetch starts at address 0
    do_word(22'd0, pat(0, 0), 1'b0, ok);
    chk("wrap_first_addr", 32'(ok), 32'd1);
    for (int w = 1; w < 10; w++) do_word(22'(w), pat(0, w), 1'b0, ok);

    // Reset mid-fetch aborts with no further requests
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd", 32'(lb_sdram_rd), 32'd0);
    @(negedge clk);
    chk("rst_mid_rd_hold", 32'(lb_sdram_rd),   32'd0);
    chk("rst_mid_addr",    32'(lb_sdram_addr), 32'd0);
    reset = 1'b1;
    fetch_line(0, 1'b0, nbad);
    chk("post_rst_line0_addrs", 32'(nbad), 32'd0);

    // Bank 1 now holds line 479
    show(10'd17, 10'd1);
    chk("px_bank1_y1", 32'(pixel), 32'hC011);
    show(10'd17, 10'd479);
    chk("px_bank1_y479", 32'(pixel), 32'hC011);
    show(10'd42, 10'd0);
    chk("px_bank0_again", 32'(pixel), 32'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
